// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave, one-word tx buffer; status flags when SPI_SLAVE_STATUS_EN is defined
module spi_slave #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             SCLK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic             clr_status,
  output logic             underrun_flag,
  output logic             abort_flag
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic               sclk_s1, sclk_s2, sclk_s3;
  logic               ss_s1, ss_s2, ss_s3;
  logic               mosi_s1, mosi_s2;
  logic [1:0]         settle;
  logic               armed;
  logic [WIDTH-1:0]   tx_shift;
  logic [WIDTH-1:0]   rx_shift;
  logic [WIDTH-1:0]   tx_buf;
  logic               buf_full;
  logic [CNT_W-1:0]   bit_cnt;
  logic               rx_pend;

  logic sclk_rise, sclk_fall, ss_fall;
  logic frame_start, abort, last_bit;

  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign ss_fall     = ~ss_s2 & ss_s3;
  assign frame_start = (state == IDLE) && ss_fall && armed;
  assign abort       = (state == SHIFT) && ss_s2;
  assign last_bit    = (bit_cnt == CNT_W'(WIDTH - 1));

  assign MISO     = (state == SHIFT) ? tx_shift[WIDTH-1] : 1'b0;
  assign tx_ready = ~buf_full;

  // Two-flop synchronizers plus a third stage used only for edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
      ss_s1   <= 1'b1; ss_s2   <= 1'b1; ss_s3   <= 1'b1;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= SCLK;    sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
      ss_s1   <= SS;      ss_s2   <= ss_s1;   ss_s3   <= ss_s2;
      mosi_s1 <= MOSI;    mosi_s2 <= mosi_s1;
    end
  end

  // After reset only accept a frame once SS has been seen high through the
  // whole chain, so a reset taken mid-frame cannot fake an SS fall
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3)
        settle <= settle + 2'd1;
      if (settle == 2'd3 && ss_s3)
        armed <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; SS high in SHIFT aborts ahead of any SCLK edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = SHIFT;
      SHIFT: begin
        if (ss_s2)
          state_nxt = IDLE;
        else if (sclk_rise && last_bit)
          state_nxt = DONE;
      end
      DONE:    if (ss_s2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers and bit counter; a load coinciding with frame start bypasses the buffer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (frame_start) begin
      tx_shift <= tx_load ? tx_data : (buf_full ? tx_buf : '0);
      bit_cnt  <= '0;
    end else if (state == SHIFT && !ss_s2) begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s2};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (sclk_fall)
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
    end
  end

  // Tx buffer: emptied at every frame start, refilled by tx_load otherwise
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_buf   <= '0;
      buf_full <= 1'b0;
    end else if (frame_start) begin
      buf_full <= 1'b0;
    end else if (tx_load) begin
      tx_buf   <= tx_data;
      buf_full <= 1'b1;
    end
  end

  // Publish the received word one cycle after the final SCLK rise
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_pend  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_pend  <= (state == SHIFT) && (state_nxt == DONE);
      rx_valid <= rx_pend;
      if (rx_pend)
        rx_data <= rx_shift;
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic underrun_set;
  assign underrun_set = frame_start && !tx_load && !buf_full;

  // Sticky status flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      underrun_flag <= 1'b0;
      abort_flag    <= 1'b0;
    end else begin
      underrun_flag <= underrun_set | (underrun_flag & ~clr_status);
      abort_flag    <= abort | (abort_flag & ~clr_status);
    end
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave (vector table, corner sequences, random frames vs model)
module tb_spi_slave;

  logic        clk, nrst, SCLK, SS, MOSI, MISO;
  logic [15:0] tx_data;
  logic        tx_load, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
`ifdef SPI_SLAVE_STATUS_EN
  logic        clr_status, underrun_flag, abort_flag;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int vcnt      = 0;

  spi_slave #(.WIDTH(16)) dut (
    .clk(clk), .nrst(nrst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef SPI_SLAVE_STATUS_EN
    , .clr_status(clr_status), .underrun_flag(underrun_flag), .abort_flag(abort_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rx_valid cycles; a pulse longer than one cycle shows up as extra counts
  always @(negedge clk) if (rx_valid === 1'b1) vcnt++;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic load(input logic [15:0] w);
    @(negedge clk); tx_data = w; tx_load = 1'b1;
    @(negedge clk); tx_load = 1'b0;
  endtask

`ifdef SPI_SLAVE_STATUS_EN
  task automatic clear_status();
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
  endtask
`endif

  task automatic check_reset_values();
    check1("rst_miso", MISO, 1'b0);
    check16("rst_rx_data", rx_data, 16'h0000);
    check1("rst_rx_valid", rx_valid, 1'b0);
    check1("rst_tx_ready", tx_ready, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
    check1("rst_underrun_flag", underrun_flag, 1'b0);
    check1("rst_abort_flag", abort_flag, 1'b0);
`endif
  endtask

  // Mode-0 master, SCLK period 16 clk; optional abort after nrise rises,
  // reset pulse before rise reset_at, tx_load aligned with frame start, tx_load mid-frame
  task automatic run_frame(input logic [15:0] mosi_w, input int nrise, input int reset_at,
                           input logic sc_load, input logic [15:0] sc_word,
                           input logic mid_load, input logic [15:0] mid_word,
                           output logic [15:0] miso_w, output logic rdy_first);
    miso_w = 16'h0000;
    rdy_first = 1'b0;
    @(negedge clk);
    SS = 1'b0;
    if (sc_load) begin
      @(posedge clk); @(posedge clk);
      @(negedge clk); tx_data = sc_word; tx_load = 1'b1;
      @(negedge clk); tx_load = 1'b0;
    end
    for (int i = 0; i < 16 && i < nrise; i++) begin
      MOSI = mosi_w[15-i];
      repeat (8) @(negedge clk);
      if (i == reset_at) begin
        nrst = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        nrst = 1'b1;
      end
      if (i == 0) rdy_first = tx_ready;
      if (mid_load && i == 5) begin
        tx_data = mid_word; tx_load = 1'b1;
        @(negedge clk); tx_load = 1'b0;
      end
      SCLK = 1'b1;
      miso_w[15-i] = MISO;
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS = 1'b1;
    MOSI = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic        do_load;
    logic [15:0] tx_word;
    logic [15:0] mosi_word;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic        exp_under;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] miso;
  logic        rdy;
  int          v0;
  logic [15:0] m_buf;
  logic        m_full;
  logic [15:0] exp_miso, w, mw, mosi_r;
  logic        do_pre, do_mid;

  initial begin
    vecs[0] = '{1'b1, 16'hAAAA, 16'hAA33, 16'hAAAA, 16'hAA33, 1'b0};
    vecs[1] = '{1'b1, 16'h0AA8, 16'h8888, 16'h0AA8, 16'h8888, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 1'b1};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0};
    vecs[4] = '{1'b1, 16'h8001, 16'hFFFE, 16'h8001, 16'hFFFE, 1'b0};

    nrst = 1'b0; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    tx_data = 16'h0000; tx_load = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    clr_status = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_values();
    nrst = 1'b1;
    repeat (10) @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      v0 = vcnt;
      if (vecs[i].do_load) begin
        load(vecs[i].tx_word);
        check1("vec_tx_ready_loaded", tx_ready, 1'b0);
      end
      run_frame(vecs[i].mosi_word, 16, -1, 1'b0, 16'h0, 1'b0, 16'h0, miso, rdy);
      check16("vec_miso_word", miso, vecs[i].exp_miso);
      check16("vec_rx_data", rx_data, vecs[i].exp_rx);
      check16("vec_rx_valid_pulses", 16'(vcnt - v0), 16'd1);
      check1("vec_tx_ready_at_start", rdy, 1'b1);
      check1("vec_tx_ready_end", tx_ready, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
      check1("vec_underrun_flag", underrun_flag, vecs[i].exp_under);
      clear_status();
`endif
    end

    // Load during frame 1 goes to frame 2
    load(16'h1111);
    run_frame(16'h0F0F, 16, -1, 1'b0, 16'h0, 1'b1, 16'hBEEF, miso, rdy);
    check16("b2b_frame1_miso", miso, 16'h1111);
    check1("b2b_tx_ready_between", tx_ready, 1'b0);
    run_frame(16'hF0F0, 16, -1, 1'b0, 16'h0, 1'b0, 16'h0, miso, rdy);
    check16("b2b_frame2_miso", miso, 16'hBEEF);
    check16("b2b_frame2_rx", rx_data, 16'hF0F0);
    check1("b2b_tx_ready_end", tx_ready, 1'b1);

    // Load coinciding with frame start bypasses and empties the buffer
    load(16'h1357);
    run_frame(16'h2222, 16, -1, 1'b1, 16'h2468, 1'b0, 16'h0, miso, rdy);
    check16("sc_miso", miso, 16'h2468);
    check1("sc_tx_ready", tx_ready, 1'b1);
    run_frame(16'h3333, 16, -1, 1'b0, 16'h0, 1'b0, 16'h0, miso, rdy);
    check16("sc_next_miso_underrun", miso, 16'h0000);
    check16("sc_next_rx", rx_data, 16'h3333);
`ifdef SPI_SLAVE_STATUS_EN
    check1("sc_underrun_flag", underrun_flag, 1'b1);
    clear_status();
    check1("clr_underrun_flag", underrun_flag, 1'b0);
`endif

    // Abort after 7 rises, then a clean frame
    load(16'h4444);
    v0 = vcnt;
    run_frame(16'hFFFF, 7, -1, 1'b0, 16'h0, 1'b0, 16'h0, miso, rdy);
    check16("abort_rx_valid_pulses", 16'(vcnt - v0), 16'd0);
    check16("abort_rx_data_held", rx_data, 16'h3333);
    check16("abort_miso_bits", miso & 16'hFE00, 16'h4400);
`ifdef SPI_SLAVE_STATUS_EN
    check1("abort_flag_set", abort_flag, 1'b1);
    clear_status();
`endif
    v0 = vcnt;
    run_frame(16'h5A5A, 16, -1, 1'b0, 16'h0, 1'b0, 16'h0, miso, rdy);
    check16("post_abort_rx", rx_data, 16'h5A5A);
    check16("post_abort_pulses", 16'(vcnt - v0), 16'd1);

    // Reset pulse before the 10th rise
    load(16'hFFFF);
    v0 = vcnt;
    run_frame(16'hAAAA, 16, 9, 1'b0, 16'h0, 1'b1, 16'h7777, miso, rdy);
    check16("rstmid_miso", miso, 16'hFF80);
    check16("rstmid_pulses", 16'(vcnt - v0), 16'd0);
    check16("rstmid_rx_data", rx_data, 16'h0000);
    check1("rstmid_tx_ready", tx_ready, 1'b1);
    v0 = vcnt;
    run_frame(16'hC3C3, 16, -1, 1'b0, 16'h0, 1'b0, 16'h0, miso, rdy);
    check16("post_rst_rx", rx_data, 16'hC3C3);
    check16("post_rst_miso", miso, 16'h0000);
    check16("post_rst_pulses", 16'(vcnt - v0), 16'd1);

    // Random frames against a buffer model
    m_buf = 16'h0000;
    m_full = 1'b0;
    for (int n = 0; n < 16; n++) begin
      do_pre = $urandom_range(0, 1) == 1;
      do_mid = $urandom_range(0, 2) == 0;
      w      = 16'($urandom);
      mw     = 16'($urandom);
      mosi_r = 16'($urandom);
      if (do_pre) begin
        load(w);
        m_buf = w;
        m_full = 1'b1;
      end
      check1("rnd_tx_ready_pre", tx_ready, ~m_full);
      exp_miso = m_full ? m_buf : 16'h0000;
      m_full = 1'b0;
      if (do_mid) begin
        m_buf = mw;
        m_full = 1'b1;
      end
      v0 = vcnt;
      run_frame(mosi_r, 16, -1, 1'b0, 16'h0, do_mid, mw, miso, rdy);
      check16("rnd_miso", miso, exp_miso);
      check16("rnd_rx_data", rx_data, mosi_r);
      check16("rnd_pulses", 16'(vcnt - v0), 16'd1);
      check1("rnd_tx_ready_post", tx_ready, ~m_full);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
